// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - shared state and result encodings for the serial magnitude comparator
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // RES_NONE is the post-reset value and drives all three result outputs low
    typedef enum logic [1:0] {
        RES_NONE = 2'd0,
        RES_GT   = 2'd1,
        RES_EQ   = 2'd2,
        RES_LT   = 2'd3
    } res_t;

    function automatic res_t bit_result(input logic gt, input logic lt);
        if (gt) begin
            return RES_GT;
        end
        if (lt) begin
            return RES_LT;
        end
        return RES_EQ;
    endfunction

endpackage

// File: rtl/serial_mag_comp_if.sv
// rtl/serial_mag_comp_if.sv - request/result bundle between a client and the serial comparator
interface serial_mag_comp_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic             o1;
    logic             o2;
    logic             o3;

    modport master (
        output start, A, B,
        input  busy, done, o1, o2, o3
    );

    modport slave (
        input  start, A, B,
        output busy, done, o1, o2, o3
    );
endinterface

// File: rtl/cmp_bit_cell.sv
// rtl/cmp_bit_cell.sv - single-bit magnitude compare cell
module cmp_bit_cell (
    input  logic a,
    input  logic b,
    output logic gt,
    output logic eq,
    output logic lt
);
    assign gt = a & ~b;
    assign lt = ~a & b;
    assign eq = ~(a ^ b);
endmodule

// File: rtl/serial_mag_comp.sv
// rtl/serial_mag_comp.sv - bit-serial MSB-first magnitude comparator
module serial_mag_comp
    import cmp_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int EARLY_EXIT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_mag_comp_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);

    state_t           state;
    state_t           state_d;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [CNT_W-1:0] cnt;
    logic             decided;
    res_t             first_diff;
    res_t             res;
    res_t             res_d;
    logic             finish;
    logic             early_stop;
    logic             cell_gt;
    logic             cell_eq;
    logic             cell_lt;

    cmp_bit_cell u_cell (
        .a  (sa[WIDTH-1]),
        .b  (sb[WIDTH-1]),
        .gt (cell_gt),
        .eq (cell_eq),
        .lt (cell_lt)
    );

    assign early_stop = (EARLY_EXIT != 0) && !cell_eq;

    always_comb begin
        state_d = state;
        finish  = 1'b0;
        res_d   = res;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                finish = early_stop || (cnt == '0);
                if (finish) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The first differing pair decides; if it is the pair under the cell
        // right now, the latch has not happened yet, so take it directly.
        if (decided) begin
            res_d = first_diff;
        end else begin
            res_d = bit_result(cell_gt, cell_lt);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sa         <= '0;
            sb         <= '0;
            cnt        <= '0;
            decided    <= 1'b0;
            first_diff <= RES_NONE;
            res        <= RES_NONE;
        end else begin
            state <= state_d;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sa      <= bus.A;
                        sb      <= bus.B;
                        cnt     <= CNT_W'(WIDTH - 1);
                        decided <= 1'b0;
                    end
                end
                RUN: begin
                    if (!cell_eq && !decided) begin
                        decided    <= 1'b1;
                        first_diff <= bit_result(cell_gt, cell_lt);
                    end
                    if (!early_stop) begin
                        sa <= sa << 1;
                        sb <= sb << 1;
                        if (cnt != '0) begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    if (finish) begin
                        res <= res_d;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = (state == DONE);
    assign bus.o1   = (res == RES_GT);
    assign bus.o2   = (res == RES_EQ);
    assign bus.o3   = (res == RES_LT);

endmodule
